// File: rtl/mm_seq_ctrl.sv
// Sequencer for the DIM x DIM signed matrix-multiply engine: walks A/B in i/j/k order,
// accumulates each dot product in one MAC, writes C. Optional busy-cycle counter: MM_PERF_CNT_EN.
module mm_seq_ctrl #(
  parameter int DIM    = 8,
  parameter int IN_W   = 8,
  parameter int OUT_W  = 19,
  parameter int ADDR_W = $clog2(DIM * DIM)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              load_mem,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] addrA,
  input  logic [IN_W-1:0]   rdA,
  output logic [ADDR_W-1:0] addrB,
  input  logic [IN_W-1:0]   rdB,
  output logic              wenC,
  output logic [ADDR_W-1:0] addrC,
  output logic [OUT_W-1:0]  wdC,
  output logic [15:0]       cyc_cnt
);

  localparam int IDX_W = (DIM > 1) ? $clog2(DIM) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIM - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic             start_accept;
  logic             abort;
  logic             load_issue;
  logic             issue_last;
  logic             drain_last_reg;
  logic             k_wrap;
  logic             j_wrap;

  logic [IDX_W-1:0] i_reg, j_reg, k_reg;
  logic [IDX_W-1:0] i_next, j_next, k_next;

  // Issue-stage tags: describe the operands currently being addressed.
  logic              iss_valid_reg;
  logic              iss_k0_reg;
  logic              iss_last_reg;
  logic [ADDR_W-1:0] iss_caddr_reg;

  // Data-stage tags: aligned with rdA/rdB, one cycle behind the issue stage.
  logic              d_valid_reg;
  logic              d_k0_reg;
  logic              d_last_reg;
  logic [ADDR_W-1:0] d_caddr_reg;

  logic signed [2*IN_W-1:0] prod_raw;
  logic signed [OUT_W-1:0]  prod;
  logic signed [OUT_W-1:0]  sum;
  logic signed [OUT_W-1:0]  acc_reg;

  function automatic logic [ADDR_W-1:0] lin_addr(input logic [IDX_W-1:0] row,
                                                  input logic [IDX_W-1:0] col);
    return ADDR_W'(row) * ADDR_W'(DIM) + ADDR_W'(col);
  endfunction

  assign k_wrap     = (k_reg == IDX_MAX);
  assign j_wrap     = (j_reg == IDX_MAX);
  assign issue_last = k_wrap && j_wrap && (i_reg == IDX_MAX);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      drain_last_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      drain_last_reg <= (state_reg == DRAIN);
    end
  end

  always_comb begin
    state_next   = state_reg;
    busy         = 1'b0;
    done         = 1'b0;
    start_accept = 1'b0;
    abort        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start && !load_mem) begin
          state_next   = RUN;
          start_accept = 1'b1;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (load_mem) begin
          state_next = IDLE;
          abort      = 1'b1;
        end else if (issue_last) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (load_mem) begin
          state_next = IDLE;
          abort      = 1'b1;
        end else if (drain_last_reg) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- issue stage
  assign load_issue = start_accept || ((state_reg == RUN) && !load_mem && !issue_last);

  always_comb begin
    if (start_accept) begin
      i_next = '0;
      j_next = '0;
      k_next = '0;
    end else begin
      k_next = k_wrap ? '0 : k_reg + IDX_W'(1);
      j_next = k_wrap ? (j_wrap ? '0 : j_reg + IDX_W'(1)) : j_reg;
      i_next = (k_wrap && j_wrap) ? i_reg + IDX_W'(1) : i_reg;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i_reg         <= '0;
      j_reg         <= '0;
      k_reg         <= '0;
      addrA         <= '0;
      addrB         <= '0;
      iss_valid_reg <= 1'b0;
      iss_k0_reg    <= 1'b0;
      iss_last_reg  <= 1'b0;
      iss_caddr_reg <= '0;
    end else if (load_issue) begin
      i_reg         <= i_next;
      j_reg         <= j_next;
      k_reg         <= k_next;
      addrA         <= lin_addr(i_next, k_next);
      addrB         <= lin_addr(k_next, j_next);
      iss_valid_reg <= 1'b1;
      iss_k0_reg    <= (k_next == '0);
      iss_last_reg  <= (k_next == IDX_MAX);
      iss_caddr_reg <= lin_addr(i_next, j_next);
    end else begin
      iss_valid_reg <= 1'b0;
    end
  end

  // ---------------------------------------------------------------- data stage / MAC
  assign prod_raw = $signed({{IN_W{rdA[IN_W-1]}}, rdA}) * $signed({{IN_W{rdB[IN_W-1]}}, rdB});
  assign prod     = {{(OUT_W - 2*IN_W){prod_raw[2*IN_W-1]}}, prod_raw};
  assign sum      = d_k0_reg ? prod : acc_reg + prod;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_valid_reg <= 1'b0;
      d_k0_reg    <= 1'b0;
      d_last_reg  <= 1'b0;
      d_caddr_reg <= '0;
    end else begin
      d_valid_reg <= iss_valid_reg && !abort;
      d_k0_reg    <= iss_k0_reg;
      d_last_reg  <= iss_last_reg;
      d_caddr_reg <= iss_caddr_reg;
    end
  end

  // An abort drops whatever is in flight, so no write lands after busy falls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_reg <= '0;
      wenC    <= 1'b0;
      addrC   <= '0;
      wdC     <= '0;
    end else begin
      wenC <= d_valid_reg && d_last_reg && !abort;
      if (d_valid_reg && !abort) begin
        acc_reg <= sum;
        if (d_last_reg) begin
          wdC   <= sum;
          addrC <= d_caddr_reg;
        end
      end
    end
  end

  // ---------------------------------------------------------------- busy-cycle counter
`ifdef MM_PERF_CNT_EN
  logic [15:0] cyc_cnt_reg;

  // The aborting cycle is not counted: busy is already considered ended there.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_cnt_reg <= '0;
    end else if (start_accept) begin
      cyc_cnt_reg <= '0;
    end else if (busy && !load_mem) begin
      cyc_cnt_reg <= cyc_cnt_reg + 16'd1;
    end
  end

  assign cyc_cnt = cyc_cnt_reg;
`else
  assign cyc_cnt = '0;
`endif

endmodule

// File: tb/tb_mm_seq_ctrl.sv
// Self-checking bench for mm_seq_ctrl: table of operand patterns with hand-computed C,
// plus directed blocked-start, abort and mid-run reset sequences.
module tb_mm_seq_ctrl;

  localparam int DIM = 8;

`ifdef MM_PERF_CNT_EN
  localparam int EXP_FULL  = 514;
  localparam int EXP_ABORT = 99;
`else
  localparam int EXP_FULL  = 0;
  localparam int EXP_ABORT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        load_mem = 1'b0;
  logic        busy, done, wenC;
  logic [5:0]  addrA, addrB, addrC;
  logic [7:0]  rdA = '0;
  logic [7:0]  rdB = '0;
  logic [18:0] wdC;
  logic [15:0] cyc_cnt;

  mm_seq_ctrl dut (
    .clk(clk), .reset(rst_n), .start(start), .load_mem(load_mem),
    .busy(busy), .done(done),
    .addrA(addrA), .rdA(rdA), .addrB(addrB), .rdB(rdB),
    .wenC(wenC), .addrC(addrC), .wdC(wdC), .cyc_cnt(cyc_cnt)
  );

  always #5 clk = ~clk;

  logic signed [7:0]  a_mem [64];
  logic signed [7:0]  b_mem [64];
  logic signed [18:0] c_mem [64];
  int                 wr_cnt [64];
  logic               clr_req = 1'b0;

  always @(posedge clk) begin
    rdA <= a_mem[addrA];
    rdB <= b_mem[addrB];
    if (clr_req) begin
      for (int a = 0; a < 64; a++) begin
        c_mem[a]  <= 19'h2AAAA;
        wr_cnt[a] <= 0;
      end
    end else if (wenC) begin
      c_mem[addrC]  <= wdC;
      wr_cnt[addrC] <= wr_cnt[addrC] + 1;
    end
  end

  typedef struct {
    string name;
    int    a_mode;  // 0: identity, 1: constant a_val
    int    a_val;
    int    b_mode;  // 0: B[r][c] = r*8+c-32, 1: constant b_val
    int    b_val;
    int    c_mode;  // 0: C equals B, 1: constant c_val, 2: c_val + 8*col
    int    c_val;
  } vec_t;

  vec_t vecs [4];
  int   n_vec = 0;
  int   n_bad = 0;

  int a1, b1, wen_cnt, first_wen_cyc, first_wen_addr, last_wen_cyc, last_wen_addr;
  int busy_cnt, busy_last, done_cnt, done_cyc;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic load_vec(input int v);
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        a_mem[r*DIM+c] = (vecs[v].a_mode == 0) ? ((r == c) ? 8'sd1 : 8'sd0) : 8'(vecs[v].a_val);
        b_mem[r*DIM+c] = (vecs[v].b_mode == 0) ? 8'(r*DIM + c - 32) : 8'(vecs[v].b_val);
      end
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
  endtask

  task automatic run_observe();
    a1 = -1; b1 = -1; wen_cnt = 0; first_wen_cyc = -1; first_wen_addr = -1;
    last_wen_cyc = -1; last_wen_addr = -1; busy_cnt = 0; busy_last = -1;
    done_cnt = 0; done_cyc = -1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 520; c++) begin
      if (c == 1) begin
        a1 = int'(addrA);
        b1 = int'(addrB);
      end
      if (busy) begin busy_cnt++; busy_last = c; end
      if (done) begin done_cnt++; done_cyc = c; end
      if (wenC) begin
        wen_cnt++;
        if (first_wen_cyc < 0) begin
          first_wen_cyc  = c;
          first_wen_addr = int'(addrC);
        end
        last_wen_cyc  = c;
        last_wen_addr = int'(addrC);
      end
      step();
    end
  endtask

  task automatic check_run(input int v);
    int exp_c;
    int once;
    load_vec(v);
    run_observe();
    chk({vecs[v].name, " addrA@1"}, a1, 0);
    chk({vecs[v].name, " addrB@1"}, b1, 0);
    chk({vecs[v].name, " wen_count"}, wen_cnt, 64);
    chk({vecs[v].name, " first_wen_cyc"}, first_wen_cyc, 10);
    chk({vecs[v].name, " first_wen_addr"}, first_wen_addr, 0);
    chk({vecs[v].name, " last_wen_cyc"}, last_wen_cyc, 514);
    chk({vecs[v].name, " last_wen_addr"}, last_wen_addr, 63);
    chk({vecs[v].name, " busy_cycles"}, busy_cnt, 514);
    chk({vecs[v].name, " busy_last"}, busy_last, 514);
    chk({vecs[v].name, " done_pulses"}, done_cnt, 1);
    chk({vecs[v].name, " done_cyc"}, done_cyc, 515);
    chk({vecs[v].name, " cyc_cnt"}, int'(cyc_cnt), EXP_FULL);
    once = 0;
    for (int a = 0; a < 64; a++) if (wr_cnt[a] == 1) once++;
    chk({vecs[v].name, " written_once"}, once, 64);
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        case (vecs[v].c_mode)
          0:       exp_c = r*DIM + c - 32;
          1:       exp_c = vecs[v].c_val;
          default: exp_c = vecs[v].c_val + 8*c;
        endcase
        chk($sformatf("%s C[%0d][%0d]", vecs[v].name, r, c), int'(c_mem[r*DIM+c]), exp_c);
      end
    $display("run %s: %0d writes, done at cycle %0d, cyc_cnt %0d",
             vecs[v].name, wen_cnt, done_cyc, cyc_cnt);
  endtask

  initial begin
    int ev;
    vecs[0] = '{"identity",  0, 0,    0, 0,    0, 0};
    vecs[1] = '{"neg_sq",    1, -128, 1, -128, 1, 131072};
    vecs[2] = '{"mixed",     1, 127,  1, -128, 1, -130048};
    vecs[3] = '{"ones_ramp", 1, 1,    0, 0,    2, -32};
    for (int a = 0; a < 64; a++) begin
      a_mem[a] = '0;
      b_mem[a] = '0;
    end

    // Reset state
    repeat (3) step();
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst wenC", int'(wenC), 0);
    chk("rst addrA", int'(addrA), 0);
    chk("rst addrC", int'(addrC), 0);
    chk("rst wdC", int'(wdC), 0);
    chk("rst cyc_cnt", int'(cyc_cnt), 0);
    rst_n = 1'b1;
    step();

    for (int v = 0; v < 4; v++) check_run(v);

    // Start blocked by load_mem, then a start during busy, then abort at cycle 100
    start = 1'b1; load_mem = 1'b1;
    step();
    chk("blocked busy", int'(busy), 0);
    start = 1'b0; load_mem = 1'b0;
    step();
    chk("blocked busy2", int'(busy), 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("abort busy@1", int'(busy), 1);
    for (int c = 1; c < 100; c++) begin
      start = (c == 50);
      step();
    end
    start = 1'b0;
    chk("abort addrA@100", int'(addrA), 11);
    chk("abort addrB@100", int'(addrB), 28);
    chk("abort busy@100", int'(busy), 1);
    load_mem = 1'b1;
    step();
    chk("abort busy@101", int'(busy), 0);
    chk("abort wenC@101", int'(wenC), 0);
    load_mem = 1'b0;
    ev = 0;
    for (int c = 0; c < 20; c++) begin
      if (done || wenC || busy) ev++;
      step();
    end
    chk("abort quiet", ev, 0);
    chk("abort cyc_cnt", int'(cyc_cnt), EXP_ABORT);
    $display("abort: busy dropped at cycle 101, cyc_cnt %0d", cyc_cnt);

    // Asynchronous reset mid-run at cycle 200, then a clean run
    load_vec(0);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 200; c++) step();
    chk("midrst busy@200", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst busy", int'(busy), 0);
    chk("midrst done", int'(done), 0);
    chk("midrst wenC", int'(wenC), 0);
    chk("midrst addrA", int'(addrA), 0);
    chk("midrst addrB", int'(addrB), 0);
    chk("midrst addrC", int'(addrC), 0);
    chk("midrst wdC", int'(wdC), 0);
    chk("midrst cyc_cnt", int'(cyc_cnt), 0);
    $display("mid-run reset: outputs busy=%0d wenC=%0d addrA=%0d", busy, wenC, addrA);
    step();
    rst_n = 1'b1;
    step();
    check_run(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
